// File: rtl/add_seq_pkg.sv
// ---------------------------------------------------------------------------
// add_seq_pkg
// Shared definitions for the sequential digit-serial adder arbiter:
//   - default operand / digit widths
//   - FSM state encoding (IDLE, CALC, RESP)
//   - round-robin grant helper for the two requesters
// ---------------------------------------------------------------------------
package add_seq_pkg;

    localparam int DEFAULT_DATA_WIDTH  = 8;
    localparam int DEFAULT_DIGIT_WIDTH = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_t;

    // One-hot grant for two requesters; prio selects the winner of a tie.
    function automatic logic [1:0] rr_grant(input logic [1:0] valid, input logic prio);
        logic [1:0] g;
        case (valid)
            2'b01:   g = 2'b01;
            2'b10:   g = 2'b10;
            2'b11:   g = prio ? 2'b10 : 2'b01;
            default: g = 2'b00;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/add_seq_slice.sv
// ---------------------------------------------------------------------------
// add_seq_slice
// Purely combinational DIGIT_WIDTH-bit adder slice with carry-in/carry-out.
// Ports:
//   a_i, b_i  : digit operands
//   cin_i     : carry-in
//   sum_o     : digit sum
//   cout_o    : carry-out of the digit MSB
// ---------------------------------------------------------------------------
module add_seq_slice #(
    parameter int DIGIT_WIDTH = 2
) (
    input  logic [DIGIT_WIDTH-1:0] a_i,
    input  logic [DIGIT_WIDTH-1:0] b_i,
    input  logic                   cin_i,
    output logic [DIGIT_WIDTH-1:0] sum_o,
    output logic                   cout_o
);

    logic [DIGIT_WIDTH:0] full_s;

    // Single-digit addition, extended by one bit to expose the carry.
    always_comb begin
        full_s = {1'b0, a_i} + {1'b0, b_i} + {{DIGIT_WIDTH{1'b0}}, cin_i};
        sum_o  = full_s[DIGIT_WIDTH-1:0];
        cout_o = full_s[DIGIT_WIDTH];
    end

endmodule

// File: rtl/add_seq_arbiter.sv
// ---------------------------------------------------------------------------
// add_seq_arbiter
// Two-requester round-robin front end for a digit-serial adder. A granted
// request's operands are captured, added DIGIT_WIDTH bits per cycle (LSB
// digit first) and the result is presented with a valid/ready handshake.
// Ports:
//   s_clock, reset        : clock, asynchronous active-high reset
//   req_valid/req_ready   : per-requester request handshake (bit i = req i)
//   req_a, req_b          : packed operands, slice i*DATA_WIDTH is req i
//   req_sub               : per-requester subtract select (ADD_SEQ_SUB_EN only)
//   rsp_valid/rsp_ready   : response handshake
//   rsp_sum, rsp_carry    : result and carry out (1 = no borrow when subtracting)
//   rsp_id                : requester that owns the result
//   busy                  : high whenever the FSM is not in IDLE
// Optional feature macro: ADD_SEQ_SUB_EN (adds req_sub and subtraction).
// DATA_WIDTH must be a multiple of DIGIT_WIDTH.
// ---------------------------------------------------------------------------
module add_seq_arbiter
    import add_seq_pkg::*;
#(
    parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter int DIGIT_WIDTH = DEFAULT_DIGIT_WIDTH
) (
    input  logic                    s_clock,
    input  logic                    reset,
    input  logic [1:0]              req_valid,
    output logic [1:0]              req_ready,
    input  logic [2*DATA_WIDTH-1:0] req_a,
    input  logic [2*DATA_WIDTH-1:0] req_b,
`ifdef ADD_SEQ_SUB_EN
    input  logic [1:0]              req_sub,
`endif
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_sum,
    output logic                    rsp_carry,
    output logic                    rsp_id,
    output logic                    busy
);

    localparam int NUM_DIGITS = DATA_WIDTH / DIGIT_WIDTH;
    localparam int CNT_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CNT_W-1:0] LAST_DIGIT = CNT_W'(NUM_DIGITS - 1);

    state_t                          state_q;
    logic                            prio_q;      // requester favoured on a tie
    logic [DATA_WIDTH-1:0]           a_q;         // shifts right one digit per cycle
    logic [DATA_WIDTH-1:0]           b_q;
    logic [DATA_WIDTH-1:0]           acc_q;       // partial sum, filled from the top
    logic                            carry_q;
    logic [CNT_W-1:0]                digit_q;
    logic                            rsp_valid_q;
    logic [DATA_WIDTH-1:0]           rsp_sum_q;
    logic                            rsp_carry_q;
    logic                            rsp_id_q;
`ifdef ADD_SEQ_SUB_EN
    logic                            sub_q;
`endif

    logic [1:0]                      grant_s;
    logic                            gid_s;
    logic [DATA_WIDTH-1:0]           a_sel_s;
    logic [DATA_WIDTH-1:0]           b_sel_s;
    logic                            first_cin_s;
    logic [DIGIT_WIDTH-1:0]          b_dig_s;
    logic [DIGIT_WIDTH-1:0]          slice_sum_s;
    logic                            slice_cout_s;
    logic [DATA_WIDTH+DIGIT_WIDTH-1:0] acc_ext_s;
    logic [DATA_WIDTH-1:0]           acc_next_s;

    // Grant only in IDLE; held off while reset is asserted so req_ready reads 0.
    always_comb begin
        grant_s = 2'b00;
        if ((state_q == IDLE) && !reset) begin
            grant_s = rr_grant(req_valid, prio_q);
        end else begin
            grant_s = 2'b00;
        end
        gid_s   = grant_s[1];
        a_sel_s = gid_s ? req_a[2*DATA_WIDTH-1:DATA_WIDTH] : req_a[DATA_WIDTH-1:0];
        b_sel_s = gid_s ? req_b[2*DATA_WIDTH-1:DATA_WIDTH] : req_b[DATA_WIDTH-1:0];
`ifdef ADD_SEQ_SUB_EN
        first_cin_s = gid_s ? req_sub[1] : req_sub[0];
`else
        first_cin_s = 1'b0;
`endif
    end

    // Current B digit; inverted for subtraction so A + ~B + 1 is formed.
    always_comb begin
`ifdef ADD_SEQ_SUB_EN
        b_dig_s = sub_q ? ~b_q[DIGIT_WIDTH-1:0] : b_q[DIGIT_WIDTH-1:0];
`else
        b_dig_s = b_q[DIGIT_WIDTH-1:0];
`endif
    end

    add_seq_slice #(
        .DIGIT_WIDTH (DIGIT_WIDTH)
    ) u_slice (
        .a_i    (a_q[DIGIT_WIDTH-1:0]),
        .b_i    (b_dig_s),
        .cin_i  (carry_q),
        .sum_o  (slice_sum_s),
        .cout_o (slice_cout_s)
    );

    // New digit enters at the top; after NUM_DIGITS shifts the sum is aligned.
    always_comb begin
        acc_ext_s  = {slice_sum_s, acc_q};
        acc_next_s = acc_ext_s[DATA_WIDTH+DIGIT_WIDTH-1:DIGIT_WIDTH];
    end

    // Control FSM with operand/result datapath registers.
    always_ff @(posedge s_clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            prio_q      <= 1'b0;
            a_q         <= {DATA_WIDTH{1'b0}};
            b_q         <= {DATA_WIDTH{1'b0}};
            acc_q       <= {DATA_WIDTH{1'b0}};
            carry_q     <= 1'b0;
            digit_q     <= {CNT_W{1'b0}};
            rsp_valid_q <= 1'b0;
            rsp_sum_q   <= {DATA_WIDTH{1'b0}};
            rsp_carry_q <= 1'b0;
            rsp_id_q    <= 1'b0;
`ifdef ADD_SEQ_SUB_EN
            sub_q       <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (|grant_s) begin
                        a_q      <= a_sel_s;
                        b_q      <= b_sel_s;
                        acc_q    <= {DATA_WIDTH{1'b0}};
                        carry_q  <= first_cin_s;
                        digit_q  <= {CNT_W{1'b0}};
                        rsp_id_q <= gid_s;
                        prio_q   <= ~gid_s;
`ifdef ADD_SEQ_SUB_EN
                        sub_q    <= first_cin_s;
`endif
                        state_q  <= CALC;
                    end else begin
                        state_q  <= IDLE;
                    end
                end
                CALC: begin
                    a_q     <= a_q >> DIGIT_WIDTH;
                    b_q     <= b_q >> DIGIT_WIDTH;
                    acc_q   <= acc_next_s;
                    carry_q <= slice_cout_s;
                    if (digit_q == LAST_DIGIT) begin
                        digit_q     <= {CNT_W{1'b0}};
                        rsp_sum_q   <= acc_next_s;
                        rsp_carry_q <= slice_cout_s;
                        rsp_valid_q <= 1'b1;
                        state_q     <= RESP;
                    end else begin
                        digit_q     <= digit_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end else begin
                        state_q     <= RESP;
                    end
                end
                default: begin
                    rsp_valid_q <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign req_ready = grant_s;
    assign rsp_valid = rsp_valid_q;
    assign rsp_sum   = rsp_sum_q;
    assign rsp_carry = rsp_carry_q;
    assign rsp_id    = rsp_id_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_add_seq_arbiter.sv
// ---------------------------------------------------------------------------
// tb_add_seq_arbiter
// Scoreboard bench for add_seq_arbiter (8-bit data, 2-bit digits).
// Expected {id, carry, sum} is pushed when a transfer happens and popped when
// the response is observed. Optional ADD_SEQ_SUB_EN enables the subtract test.
// ---------------------------------------------------------------------------
module tb_add_seq_arbiter;

    localparam int DW = 8;

    logic          s_clock;
    logic          reset;
    logic [1:0]    req_valid;
    logic [1:0]    req_ready;
    logic [2*DW-1:0] req_a;
    logic [2*DW-1:0] req_b;
`ifdef ADD_SEQ_SUB_EN
    logic [1:0]    req_sub;
`endif
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_sum;
    logic          rsp_carry;
    logic          rsp_id;
    logic          busy;

    int errors = 0;
    int checks = 0;
    logic [9:0] exp_q[$];   // {id, carry, sum}

    add_seq_arbiter #(.DATA_WIDTH(8), .DIGIT_WIDTH(2)) dut (
        .s_clock   (s_clock),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
`ifdef ADD_SEQ_SUB_EN
        .req_sub   (req_sub),
`endif
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_sum   (rsp_sum),
        .rsp_carry (rsp_carry),
        .rsp_id    (rsp_id),
        .busy      (busy)
    );

    initial s_clock = 1'b0;
    always #5 s_clock = ~s_clock;

    function automatic logic [9:0] model(input int id, input logic [7:0] a, input logic [7:0] b, input logic sub);
        logic [8:0] r;
        if (sub) r = {1'b0, a} + {1'b0, ~b} + 9'd1;
        else     r = {1'b0, a} + {1'b0, b};
        return {(id == 1) ? 1'b1 : 1'b0, r};
    endfunction

    task automatic apply_reset();
        reset = 1'b1;
        repeat (2) @(posedge s_clock);
        @(negedge s_clock);
        reset = 1'b0;
    endtask

    // Present a request and wait (bounded) for its transfer; push the expectation.
    task automatic send(input int id, input logic [7:0] a, input logic [7:0] b, input logic sub, output bit ok);
        @(negedge s_clock);
        req_a[id*8 +: 8] = a;
        req_b[id*8 +: 8] = b;
`ifdef ADD_SEQ_SUB_EN
        req_sub[id] = sub;
`endif
        req_valid[id] = 1'b1;
        ok = 1'b0;
        for (int n = 0; n < 40 && !ok; n++) begin
            #1;
            if (req_ready[id] === 1'b1) begin
                ok = 1'b1;
                @(posedge s_clock);
                #1;
                req_valid[id] = 1'b0;
                req_a = 16'($urandom);
                req_b = 16'($urandom);
`ifdef ADD_SEQ_SUB_EN
                req_sub = 2'($urandom);
`endif
            end else begin
                @(negedge s_clock);
            end
        end
        if (ok) exp_q.push_back(model(id, a, b, sub));
    endtask

    // Wait (bounded) for rsp_valid, capture the result, then complete the handshake.
    task automatic get_rsp(output bit ok, output logic [9:0] got, output int waited);
        ok = 1'b0;
        waited = 0;
        got = 10'd0;
        for (int n = 1; n <= 40 && !ok; n++) begin
            @(negedge s_clock);
            if (rsp_valid === 1'b1) begin
                ok = 1'b1;
                waited = n;
                got = {rsp_id, rsp_carry, rsp_sum};
            end
        end
        if (ok) begin
            rsp_ready = 1'b1;
            @(posedge s_clock);
            #1;
            rsp_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        req_valid = 2'b11;
        reset = 1'b1;
        #2;
        checks++;
        if ({rsp_valid, rsp_sum, rsp_carry, rsp_id, busy, req_ready} !== 13'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 0", {rsp_valid, rsp_sum, rsp_carry, rsp_id, busy, req_ready});
        end
        req_valid = 2'b00;
        apply_reset();
    endtask

    task automatic test_basic();
        bit ok;
        logic [9:0] got;
        logic [9:0] exp;
        int waited;
        send(0, 8'h5A, 8'h3C, 1'b0, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL basic_grant: no transfer within budget"); end
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b expected 1", busy); end
        get_rsp(ok, got, waited);
        exp = exp_q.pop_front();
        checks++;
        if (!ok) begin errors++; $display("FAIL basic_rsp: timeout"); end
        else if (got !== exp) begin errors++; $display("FAIL basic_rsp: got %h expected %h", got, exp); end
        checks++;
        if (waited !== 5) begin errors++; $display("FAIL basic_latency: got %0d expected 5", waited); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL basic_idle: busy got %b expected 0", busy); end
    endtask

    task automatic test_carry();
        bit ok;
        logic [9:0] got;
        logic [9:0] exp;
        int waited;
        send(1, 8'hFF, 8'h01, 1'b0, ok);
        get_rsp(ok, got, waited);
        exp = exp_q.pop_front();
        checks++;
        if (!ok) begin errors++; $display("FAIL carry_rsp: timeout"); end
        else if (got !== exp) begin errors++; $display("FAIL carry_rsp: got %h expected %h", got, exp); end
    endtask

    task automatic test_tie();
        bit ok;
        logic [9:0] got;
        logic [9:0] exp;
        int waited;
        int order [4] = '{0, 1, 0, 1};
        apply_reset();
        req_a = {8'hF0, 8'h12};
        req_b = {8'h20, 8'h34};
        req_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            int gid;
            int cyc;
            gid = -1;
            cyc = 0;
            for (int n = 1; n <= 20 && gid < 0; n++) begin
                if (n > 1 || k > 0) @(negedge s_clock);
                #1;
                if (req_ready == 2'b01) gid = 0;
                else if (req_ready == 2'b10) gid = 1;
                cyc = n;
            end
            checks++;
            if (gid != order[k]) begin errors++; $display("FAIL tie_order%0d: got %0d expected %0d", k, gid, order[k]); end
            if (k > 0) begin
                checks++;
                if (cyc != 1) begin errors++; $display("FAIL tie_bubble%0d: got %0d cycles expected 1", k, cyc); end
            end
            if (gid >= 0) begin
                exp_q.push_back(model(gid, req_a[gid*8 +: 8], req_b[gid*8 +: 8], 1'b0));
                @(posedge s_clock);
                #1;
                if (k == 3) req_valid = 2'b00;
                get_rsp(ok, got, waited);
                exp = exp_q.pop_front();
                checks++;
                if (!ok) begin errors++; $display("FAIL tie_rsp%0d: timeout", k); end
                else if (got !== exp) begin errors++; $display("FAIL tie_rsp%0d: got %h expected %h", k, got, exp); end
            end
        end
        req_valid = 2'b00;
    endtask

    task automatic test_backpressure();
        bit ok;
        logic [9:0] exp;
        bit seen;
        send(0, 8'h77, 8'h11, 1'b0, ok);
        exp = exp_q.pop_front();
        seen = 1'b0;
        for (int n = 0; n < 40 && !seen; n++) begin
            @(negedge s_clock);
            if (rsp_valid === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen) begin errors++; $display("FAIL bp_valid: timeout"); end
        req_a[15:8] = 8'h01;
        req_b[15:8] = 8'h01;
        req_valid = 2'b10;
        for (int c = 0; c < 10; c++) begin
            checks++;
            if ({rsp_valid, busy, req_ready, rsp_id, rsp_carry, rsp_sum} !== {1'b1, 1'b1, 2'b00, exp}) begin
                errors++;
                $display("FAIL bp_hold%0d: got %h expected %h", c,
                         {rsp_valid, busy, req_ready, rsp_id, rsp_carry, rsp_sum}, {1'b1, 1'b1, 2'b00, exp});
            end
            @(negedge s_clock);
        end
        req_valid = 2'b00;
        rsp_ready = 1'b1;
        @(posedge s_clock);
        #1;
        rsp_ready = 1'b0;
        checks++;
        if (rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_release: rsp_valid got %b expected 0", rsp_valid); end
    endtask

    task automatic test_reset_mid_calc();
        bit ok;
        logic [9:0] got;
        logic [9:0] exp;
        int waited;
        send(1, 8'h33, 8'h44, 1'b0, ok);
        @(posedge s_clock);
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({rsp_valid, rsp_sum, rsp_carry, rsp_id, busy, req_ready} !== 13'd0) begin
            errors++;
            $display("FAIL midreset_outputs: got %h expected 0", {rsp_valid, rsp_sum, rsp_carry, rsp_id, busy, req_ready});
        end
        exp_q.delete();
        @(negedge s_clock);
        reset = 1'b0;
        send(0, 8'hA5, 8'h5A, 1'b0, ok);
        get_rsp(ok, got, waited);
        exp = exp_q.pop_front();
        checks++;
        if (!ok) begin errors++; $display("FAIL midreset_next: timeout"); end
        else if (got !== exp) begin errors++; $display("FAIL midreset_next: got %h expected %h", got, exp); end
    endtask

    task automatic test_random();
        bit ok;
        logic [9:0] got;
        logic [9:0] exp;
        int waited;
        for (int k = 0; k < 8; k++) begin
            int id;
            logic sub;
            id = int'($urandom_range(1, 0));
`ifdef ADD_SEQ_SUB_EN
            sub = 1'($urandom);
`else
            sub = 1'b0;
`endif
            send(id, 8'($urandom), 8'($urandom), sub, ok);
            get_rsp(ok, got, waited);
            exp = exp_q.pop_front();
            checks++;
            if (!ok) begin errors++; $display("FAIL random%0d: timeout", k); end
            else if (got !== exp) begin errors++; $display("FAIL random%0d: got %h expected %h", k, got, exp); end
        end
    endtask

`ifdef ADD_SEQ_SUB_EN
    task automatic test_sub();
        bit ok;
        logic [9:0] got;
        int waited;
        send(0, 8'h10, 8'h01, 1'b1, ok);
        get_rsp(ok, got, waited);
        void'(exp_q.pop_front());
        checks++;
        if (!ok) begin errors++; $display("FAIL sub_rsp: timeout"); end
        else if (got !== 10'h10F) begin errors++; $display("FAIL sub_rsp: got %h expected 10f", got); end
    endtask
`endif

    initial begin
        reset = 1'b0;
        req_valid = 2'b00;
        req_a = 16'd0;
        req_b = 16'd0;
`ifdef ADD_SEQ_SUB_EN
        req_sub = 2'b00;
`endif
        rsp_ready = 1'b0;
        test_reset();
        test_basic();
        test_carry();
        test_tie();
        test_backpressure();
        test_reset_mid_calc();
        test_random();
`ifdef ADD_SEQ_SUB_EN
        test_sub();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
